// File: rtl/op_issue_sequencer.sv
// Issue sequencer for the ALU control interface: request FIFO, op_select/operand issue FSM and a valid/ready result channel.
// Optional macro OP_ISSUE_ILLEGAL_TRAP_EN drops op codes 110/111 and pulses illegal_flag instead of issuing them.
module op_issue_sequencer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2:0]                      in_op,
    input  logic [DATA_W-1:0]               in_a,
    input  logic [DATA_W-1:0]               in_b,
    output logic [2:0]                      op_select,
    output logic [DATA_W-1:0]               alu_a,
    output logic [DATA_W-1:0]               alu_b,
    output logic                            busy,
    input  logic [DATA_W-1:0]               alu_result,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [DATA_W-1:0]               res_data,
    output logic [2:0]                      res_op,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            illegal_flag
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MUL = LAT_W'(MUL_LAT);
    localparam logic [LAT_W-1:0] LAT_DIV = LAT_W'(DIV_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    function automatic logic [LAT_W-1:0] op_latency(input logic [2:0] op);
        logic [LAT_W-1:0] lat;
        case (op)
            3'b100:  lat = LAT_MUL;
            3'b101:  lat = LAT_DIV;
            default: lat = LAT_ONE;
        endcase
        return lat;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_mem_op [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_a  [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_b  [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_in_ready;
    logic                r_busy;
    logic [2:0]          r_op_sel;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic [2:0]          r_res_op;
    logic                w_push;
    logic                w_pop;
    logic                w_illegal;
    logic [2:0]          w_head_op;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = (r_state == S_IDLE) & (r_count != {CNT_W{1'b0}});
    assign w_head_op = r_mem_op[r_rd_ptr];
    assign w_head_a  = r_mem_a[r_rd_ptr];
    assign w_head_b  = r_mem_b[r_rd_ptr];

`ifdef OP_ISSUE_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign w_illegal = w_head_op[2] & w_head_op[1];

    // One-cycle pulse following the pop of a trapped op code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_pop & w_illegal;
        end
    end
    assign illegal_flag = r_illegal;
`else
    assign w_illegal    = 1'b0;
    assign illegal_flag = 1'b0;
`endif

    // FIFO occupancy after this edge; a push at full is already blocked by r_in_ready
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, no reset needed since entries are only read below the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= in_op;
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
        end
    end

    // FIFO pointers, count and registered accept flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < DEPTH_C);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop && !w_illegal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                if (r_lat_cnt == LAT_ONE) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Issue registers, latency counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_sel    <= 3'b000;
            r_alu_a     <= {DATA_W{1'b0}};
            r_alu_b     <= {DATA_W{1'b0}};
            r_lat_cnt   <= {LAT_W{1'b0}};
            r_res_valid <= 1'b0;
            r_res_data  <= {DATA_W{1'b0}};
            r_res_op    <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop && !w_illegal) begin
                        r_op_sel  <= w_head_op;
                        r_alu_a   <= w_head_a;
                        r_alu_b   <= w_head_b;
                        r_lat_cnt <= op_latency(w_head_op);
                    end else begin
                        r_op_sel  <= 3'b000;
                        r_alu_a   <= {DATA_W{1'b0}};
                        r_alu_b   <= {DATA_W{1'b0}};
                    end
                end
                S_EXEC: begin
                    if (r_lat_cnt == LAT_ONE) begin
                        r_res_data  <= alu_result;
                        r_res_op    <= r_op_sel;
                        r_res_valid <= 1'b1;
                        r_op_sel    <= 3'b000;
                        r_alu_a     <= {DATA_W{1'b0}};
                        r_alu_b     <= {DATA_W{1'b0}};
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_ONE;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign fifo_count = r_count;
    assign busy       = r_busy;
    assign op_select  = r_op_sel;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_op     = r_res_op;

endmodule

// File: tb/tb_op_issue_sequencer.sv
// Directed self-checking bench for op_issue_sequencer with a behavioural reference ALU.
module tb_op_issue_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] op_select;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       busy;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic [2:0] fifo_count;
    logic       illegal_flag;

    int n_checks = 0;
    int n_fail   = 0;

    op_issue_sequencer #(.DATA_W(8), .FIFO_DEPTH(4), .MUL_LAT(3), .DIV_LAT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .op_select(op_select),
        .alu_a(alu_a), .alu_b(alu_b), .busy(busy), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .fifo_count(fifo_count), .illegal_flag(illegal_flag)
    );

    always #5 clk = ~clk;

    // Reference ALU standing in for the datapath
    always_comb begin
        case (op_select)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a * alu_b;
            3'b101:  alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp_d, input logic [2:0] exp_op);
        int k = 0;
        while (!res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_valid"}, 32'(res_valid), 1);
        check_eq({tag, "_data"}, 32'(res_data), 32'(exp_d));
        check_eq({tag, "_op"}, 32'(res_op), 32'(exp_op));
        @(posedge clk);
        #1;
    endtask

    logic [2:0] v_op [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [7:0] v_a  [5] = '{8'd1, 8'd9, 8'd12, 8'd5, 8'd100};
    logic [7:0] v_b  [5] = '{8'd2, 8'd3, 8'd10, 8'd3, 8'd50};
    logic [7:0] v_r  [5] = '{8'd3, 8'd6, 8'd8, 8'd7, 8'd150};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 8'd0; in_b = 8'd0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_op_select", 32'(op_select), 0);
        check_eq("rst_alu_a", 32'(alu_a), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_fifo_count", 32'(fifo_count), 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_illegal", 32'(illegal_flag), 0);
        rst_n = 1'b1;

        // ADD 3+4, single-cycle op
        push_one(3'd0, 8'd3, 8'd4);
        @(negedge clk);
        check_eq("add_buffered", 32'(fifo_count), 1);
        check_eq("add_not_busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("add_alu_a", 32'(alu_a), 3);
        check_eq("add_alu_b", 32'(alu_b), 4);
        check_eq("add_busy", 32'(busy), 1);
        check_eq("add_no_res_yet", 32'(res_valid), 0);
        @(negedge clk);
        check_eq("add_res_valid", 32'(res_valid), 1);
        check_eq("add_res_data", 32'(res_data), 7);
        check_eq("add_res_op", 32'(res_op), 0);
        check_eq("add_alu_a_cleared", 32'(alu_a), 0);
        @(negedge clk);
        check_eq("add_handshake", 32'(res_valid), 0);
        check_eq("add_idle", 32'(busy), 0);

        // MUL 5*6 held for exactly MUL_LAT cycles
        push_one(3'd4, 8'd5, 8'd6);
        @(negedge clk);
        check_eq("mul_buffered", 32'(fifo_count), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("mul_op_select", 32'(op_select), 4);
            check_eq("mul_no_res", 32'(res_valid), 0);
        end
        @(negedge clk);
        check_eq("mul_res_valid", 32'(res_valid), 1);
        check_eq("mul_res_data", 32'(res_data), 30);
        check_eq("mul_res_op", 32'(res_op), 4);
        check_eq("mul_op_cleared", 32'(op_select), 0);
        @(negedge clk);

        // Five back-to-back pushes under back-pressure, then a push attempt at full
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = v_op[i]; in_a = v_a[i]; in_b = v_b[i];
            @(negedge clk);
        end
        check_eq("full_count", 32'(fifo_count), 4);
        check_eq("full_in_ready", 32'(in_ready), 0);
        check_eq("full_first_res", 32'(res_data), 3);
        check_eq("full_busy", 32'(busy), 1);
        in_op = 3'd1; in_a = 8'd99; in_b = 8'd1;
        @(negedge clk);
        check_eq("full_no_push", 32'(fifo_count), 4);
        in_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_result($sformatf("burst%0d", i), v_r[i], v_op[i]);
        end
        @(negedge clk);
        check_eq("burst_drained", 32'(fifo_count), 0);

        // SUB 9-2 stalled by res_ready=0 while the FIFO keeps accepting
        res_ready = 1'b0;
        push_one(3'd1, 8'd9, 8'd2);
        for (int k = 0; k < 20 && !res_valid; k++) @(negedge clk);
        push_one(3'd0, 8'd1, 8'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(res_valid), 1);
            check_eq("stall_data", 32'(res_data), 7);
            check_eq("stall_busy", 32'(busy), 1);
            check_eq("stall_no_issue", 32'(alu_a), 0);
            check_eq("stall_fifo", 32'(fifo_count), 1);
        end
        res_ready = 1'b1;
        wait_result("stall_sub", 8'd7, 3'd1);
        wait_result("stall_add", 8'd2, 3'd0);

        // DIV interrupted by reset on its third EXEC cycle, second DIV still buffered
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_a = 8'd20; in_b = 8'd4;
        @(negedge clk);
        in_op = 3'd5; in_a = 8'd9; in_b = 8'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("div_exec1", 32'(op_select), 5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("div_rst_op_select", 32'(op_select), 0);
        check_eq("div_rst_alu_a", 32'(alu_a), 0);
        check_eq("div_rst_busy", 32'(busy), 0);
        check_eq("div_rst_res_data", 32'(res_data), 0);
        check_eq("div_rst_fifo", 32'(fifo_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("div_post_busy", 32'(busy), 0);
        check_eq("div_post_valid", 32'(res_valid), 0);
        check_eq("div_post_fifo", 32'(fifo_count), 0);

        // DIV by zero, held for DIV_LAT cycles, ALU value passed through
        push_one(3'd5, 8'd9, 8'd0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("divz_op_select", 32'(op_select), 5);
            check_eq("divz_no_res", 32'(res_valid), 0);
        end
        @(negedge clk);
        check_eq("divz_res_valid", 32'(res_valid), 1);
        check_eq("divz_res_data", 32'(res_data), 255);
        check_eq("divz_res_op", 32'(res_op), 5);
        @(negedge clk);

        // Op code 110
        push_one(3'd6, 8'd3, 8'd5);
        @(negedge clk);
        check_eq("ill_buffered", 32'(fifo_count), 1);
        @(negedge clk);
`ifdef OP_ISSUE_ILLEGAL_TRAP_EN
        check_eq("ill_flag_high", 32'(illegal_flag), 1);
        check_eq("ill_not_busy", 32'(busy), 0);
        check_eq("ill_op_select", 32'(op_select), 0);
        @(negedge clk);
        check_eq("ill_flag_low", 32'(illegal_flag), 0);
        check_eq("ill_fifo", 32'(fifo_count), 0);
        for (int k = 0; k < 3; k++) begin
            check_eq("ill_no_res", 32'(res_valid), 0);
            @(negedge clk);
        end
`else
        check_eq("ill_op_select", 32'(op_select), 6);
        check_eq("ill_flag_tied", 32'(illegal_flag), 0);
        @(negedge clk);
        check_eq("ill_res_valid", 32'(res_valid), 1);
        check_eq("ill_res_data", 32'(res_data), 6);
        check_eq("ill_res_op", 32'(res_op), 6);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
